// File: rtl/cpu_types_pkg.sv
// Basic datapath types shared across the pipelined MIPS core.
package cpu_types_pkg;
    localparam int WORD_W = 32;
    typedef logic [WORD_W-1:0] word_t;
endpackage

// File: rtl/data_path_muxs_pkg.sv
// Datapath mux selections, fetch FSM states and the reset PC shared by the fetch stage.
package data_path_muxs_pkg;
    import cpu_types_pkg::*;

    typedef enum logic [1:0] {
        PC_NPC    = 2'd0,
        PC_BRANCH = 2'd1,
        PC_JUMP   = 2'd2,
        PC_JR     = 2'd3
    } pc_mux_input_selection;

    typedef enum logic {
        FETCH  = 1'b0,
        HALTED = 1'b1
    } fetch_state_t;

    localparam word_t PC_INIT_DEFAULT = 32'h0000_0000;

    // Instruction addresses are word aligned; every PC load goes through this.
    function automatic word_t align_word(input word_t addr);
        return addr & ~word_t'(3);
    endfunction
endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory port between the fetch stage (master) and instruction memory (slave).
interface fetch_stage_if;
    import cpu_types_pkg::*;

    // Handshake: the fetch stage holds imemREN high with a stable imemaddr until memory
    // answers with ihit, which qualifies imemload for that address in the same cycle.
    logic  ihit;
    word_t imemload;
    logic  imemREN;
    word_t imemaddr;

    modport master (input ihit, imemload, output imemREN, imemaddr);
    modport slave  (output ihit, imemload, input imemREN, imemaddr);
endinterface

// File: rtl/if_id_latch.sv
// IF/ID pipeline register: clear beats hold beats load; with none asserted it inserts a bubble.
module if_id_latch
    import cpu_types_pkg::*;
(
    input  logic        CLK,
    input  logic        nRST,
    input  logic        load,
    input  logic        clear,
    input  logic        hold,
    input  word_t       instr_in,
    input  word_t       npc_in,
    output word_t       instr,
    output word_t       npc,
    output logic        valid,
    output logic [5:0]  opcode,
    output logic [5:0]  func,
    output logic [15:0] imm16
);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            instr <= '0;
            npc   <= '0;
            valid <= 1'b0;
        end else if (clear) begin
            instr <= '0;
            npc   <= '0;
            valid <= 1'b0;
        end else if (!hold) begin
            if (load) begin
                instr <= instr_in;
                npc   <= npc_in;
                valid <= 1'b1;
            end else begin
                // Bubble: instr/npc keep their old contents but are no longer live.
                valid <= 1'b0;
            end
        end
    end

    assign opcode = instr[31:26];
    assign func   = instr[5:0];
    assign imm16  = instr[15:0];

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, next-PC mux, FETCH/HALTED FSM and the IF/ID latch.
// Optional FETCH_PERF_EN adds fetch_count / stall_count performance counters.
module fetch_stage
    import cpu_types_pkg::*;
    import data_path_muxs_pkg::*;
#(
    parameter word_t PC_INIT = PC_INIT_DEFAULT
) (
    input  logic                  CLK,
    input  logic                  nRST,
    fetch_stage_if.master         imem,
    input  pc_mux_input_selection PCSrc,
    input  logic                  halt,
    input  logic                  stall,
    input  logic                  flush,
    input  word_t                 branch_addr,
    input  word_t                 jr_addr,
    output word_t                 instr_IF_ID,
    output word_t                 npc_IF_ID,
    output logic                  valid_IF_ID,
    output logic [5:0]            opcode_IF_ID,
    output logic [5:0]            func_IF_ID,
    output logic [15:0]           imm16,
    output logic                  halted,
    output fetch_state_t          state
`ifdef FETCH_PERF_EN
    ,
    output word_t                 fetch_count,
    output word_t                 stall_count
`endif
);

    fetch_state_t state_q, state_d;
    word_t        pc_q, pc_d;
    word_t        pc_plus4;
    word_t        redirect_target;
    logic         latch_load, latch_clear, latch_hold;
    logic         accept;

    assign pc_plus4 = pc_q + 32'd4;

    always_comb begin
        redirect_target = pc_plus4;
        case (PCSrc)
            PC_BRANCH: redirect_target = branch_addr;
            PC_JR:     redirect_target = jr_addr;
            // Jump target uses the region bits of the jump's own PC+4 held in IF/ID.
            PC_JUMP:   redirect_target = {npc_IF_ID[31:28], instr_IF_ID[25:0], 2'b00};
            default:   redirect_target = pc_plus4;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        latch_load  = 1'b0;
        latch_clear = 1'b0;
        latch_hold  = 1'b0;
        accept      = 1'b0;
        case (state_q)
            FETCH: begin
                if (halt) begin
                    state_d     = HALTED;
                    latch_clear = 1'b1;
                end else if (PCSrc != PC_NPC) begin
                    pc_d        = align_word(redirect_target);
                    latch_clear = 1'b1;
                end else if (flush) begin
                    latch_clear = 1'b1;
                    if (imem.ihit) pc_d = align_word(pc_plus4);
                end else if (stall) begin
                    latch_hold = 1'b1;
                end else if (imem.ihit) begin
                    latch_load = 1'b1;
                    accept     = 1'b1;
                    pc_d       = align_word(pc_plus4);
                end
            end
            default: begin
                latch_hold = 1'b1;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= FETCH;
            pc_q    <= PC_INIT;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    assign imem.imemREN  = (state_q == FETCH);
    assign imem.imemaddr = pc_q;
    assign halted        = (state_q == HALTED);
    assign state         = state_q;

    if_id_latch u_if_id (
        .CLK      (CLK),
        .nRST     (nRST),
        .load     (latch_load),
        .clear    (latch_clear),
        .hold     (latch_hold),
        .instr_in (imem.imemload),
        .npc_in   (pc_plus4),
        .instr    (instr_IF_ID),
        .npc      (npc_IF_ID),
        .valid    (valid_IF_ID),
        .opcode   (opcode_IF_ID),
        .func     (func_IF_ID),
        .imm16    (imm16)
    );

`ifdef FETCH_PERF_EN
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            fetch_count <= '0;
            stall_count <= '0;
        end else if (state_q == FETCH) begin
            if (accept) fetch_count <= fetch_count + 32'd1;
            if (stall || !imem.ihit) stall_count <= stall_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: accepted fetches go into a scoreboard queue and are
// popped when IF/ID presents them; control cases are checked against a bench-side PC model.
module tb_fetch_stage;
    import cpu_types_pkg::*;
    import data_path_muxs_pkg::*;

    logic                  CLK = 1'b0;
    logic                  nRST;
    pc_mux_input_selection PCSrc;
    logic                  halt, stall, flush;
    word_t                 branch_addr, jr_addr;
    word_t                 instr_IF_ID, npc_IF_ID;
    logic                  valid_IF_ID;
    logic [5:0]            opcode_IF_ID, func_IF_ID;
    logic [15:0]           imm16;
    logic                  halted;
    fetch_state_t          state;
`ifdef FETCH_PERF_EN
    word_t                 fetch_count, stall_count;
`endif

    fetch_stage_if imem();

    fetch_stage dut (
        .CLK          (CLK),
        .nRST         (nRST),
        .imem         (imem),
        .PCSrc        (PCSrc),
        .halt         (halt),
        .stall        (stall),
        .flush        (flush),
        .branch_addr  (branch_addr),
        .jr_addr      (jr_addr),
        .instr_IF_ID  (instr_IF_ID),
        .npc_IF_ID    (npc_IF_ID),
        .valid_IF_ID  (valid_IF_ID),
        .opcode_IF_ID (opcode_IF_ID),
        .func_IF_ID   (func_IF_ID),
        .imm16        (imm16),
        .halted       (halted),
        .state        (state)
`ifdef FETCH_PERF_EN
        ,
        .fetch_count  (fetch_count),
        .stall_count  (stall_count)
`endif
    );

    always #5 CLK = ~CLK;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [63:0] exp_q[$];
    word_t       exp_pc;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        imem.ihit = 1'b0;
        stall     = 1'b0;
        flush     = 1'b0;
        halt      = 1'b0;
        PCSrc     = PC_NPC;
    endtask

    task automatic pop_compare(input string tag);
        logic [63:0] e;
        check({tag, "_valid"}, 64'(valid_IF_ID), 64'd1);
        check({tag, "_sb_nonempty"}, 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check({tag, "_instr"}, 64'(instr_IF_ID), 64'(e[63:32]));
            check({tag, "_npc"}, 64'(npc_IF_ID), 64'(e[31:0]));
        end
    endtask

    // One accepted fetch: address check, push expectation, clock, pop and compare.
    task automatic hit(input string tag, input word_t w);
        check({tag, "_addr"}, 64'(imem.imemaddr), 64'(exp_pc));
        imem.ihit     = 1'b1;
        imem.imemload = w;
        exp_q.push_back({w, exp_pc + 32'd4});
        step();
        imem.ihit = 1'b0;
        exp_pc    = exp_pc + 32'd4;
        pop_compare(tag);
        check({tag, "_next_addr"}, 64'(imem.imemaddr), 64'(exp_pc));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        word_t a, b, c, d;
        idle_inputs();
        nRST          = 1'b0;
        imem.imemload = '0;
        branch_addr   = '0;
        jr_addr       = '0;
        exp_pc        = 32'h0;
        a = 32'h8C43_1234;
        b = $urandom;
        c = $urandom;
        d = $urandom;

        // Reset values
        #3;
        check("rst_addr", 64'(imem.imemaddr), 64'h0);
        check("rst_ren", 64'(imem.imemREN), 64'd1);
        check("rst_instr", 64'(instr_IF_ID), 64'h0);
        check("rst_npc", 64'(npc_IF_ID), 64'h0);
        check("rst_valid", 64'(valid_IF_ID), 64'd0);
        check("rst_fields", {opcode_IF_ID, func_IF_ID, imm16}, 64'h0);
        check("rst_halted", 64'(halted), 64'd0);
        check("rst_state", 64'(state), 64'(FETCH));
`ifdef FETCH_PERF_EN
        check("rst_fetch_count", 64'(fetch_count), 64'd0);
        check("rst_stall_count", 64'(stall_count), 64'd0);
`endif
        #9;
        nRST = 1'b1;
        #1;

        // Sequential fetch of A, B, C
        hit("seq_a", a);
        check("seq_a_fields", {opcode_IF_ID, func_IF_ID, imm16}, {6'h23, 6'h34, 16'h1234});
        hit("seq_b", b);
        hit("seq_c", c);
        check("seq_addr12", 64'(imem.imemaddr), 64'hC);
`ifdef FETCH_PERF_EN
        check("perf_fetch3", 64'(fetch_count), 64'd3);
        check("perf_stall0", 64'(stall_count), 64'd0);
`endif

        // No hit: bubble, instr holds
        step();
        check("bubble_valid", 64'(valid_IF_ID), 64'd0);
        check("bubble_instr", 64'(instr_IF_ID), 64'(c));
        check("bubble_addr", 64'(imem.imemaddr), 64'(exp_pc));

        // Stall with hit for two cycles, then release
        stall = 1'b1;
        imem.ihit = 1'b1;
        imem.imemload = d;
        for (int i = 0; i < 2; i++) begin
            step();
            check("stall_addr", 64'(imem.imemaddr), 64'(exp_pc));
            check("stall_valid", 64'(valid_IF_ID), 64'd0);
            check("stall_instr", 64'(instr_IF_ID), 64'(c));
        end
        idle_inputs();
        hit("stall_release", d);

        // Flush without hit: clear, PC holds
        flush = 1'b1;
        step();
        idle_inputs();
        check("flush_instr", 64'(instr_IF_ID), 64'h0);
        check("flush_npc", 64'(npc_IF_ID), 64'h0);
        check("flush_valid", 64'(valid_IF_ID), 64'd0);
        check("flush_addr", 64'(imem.imemaddr), 64'(exp_pc));

        // Flush with hit: clear, PC advances
        flush = 1'b1;
        imem.ihit = 1'b1;
        imem.imemload = $urandom;
        step();
        idle_inputs();
        exp_pc = exp_pc + 32'd4;
        check("flush_hit_addr", 64'(imem.imemaddr), 64'(exp_pc));
        check("flush_hit_valid", 64'(valid_IF_ID), 64'd0);

        // Branch over a pending hit (misaligned target gets aligned)
        hit("pre_branch", $urandom);
        PCSrc = PC_BRANCH;
        branch_addr = 32'h43;
        imem.ihit = 1'b1;
        imem.imemload = 32'hDEAD_BEEF;
        step();
        idle_inputs();
        exp_pc = 32'h40;
        check("branch_addr", 64'(imem.imemaddr), 64'h40);
        check("branch_valid", 64'(valid_IF_ID), 64'd0);
        check("branch_instr", 64'(instr_IF_ID), 64'h0);
        hit("post_branch", $urandom);

        // Jump from 0x1000_0000 with instr 0x0800_0010
        PCSrc = PC_BRANCH;
        branch_addr = 32'h1000_0000;
        step();
        idle_inputs();
        exp_pc = 32'h1000_0000;
        hit("jump_src", 32'h0800_0010);
        check("jump_fields", {opcode_IF_ID, func_IF_ID, imm16}, {6'h02, 6'h10, 16'h0010});
        PCSrc = PC_JUMP;
        step();
        idle_inputs();
        exp_pc = 32'h1000_0040;
        check("jump_addr", 64'(imem.imemaddr), 64'h1000_0040);
        check("jump_valid", 64'(valid_IF_ID), 64'd0);

        // JR with misaligned register target
        PCSrc = PC_JR;
        jr_addr = 32'h0000_0202;
        step();
        idle_inputs();
        exp_pc = 32'h200;
        check("jr_addr", 64'(imem.imemaddr), 64'h200);

        // Wrap at top of address space
        PCSrc = PC_BRANCH;
        branch_addr = 32'hFFFF_FFFC;
        step();
        idle_inputs();
        exp_pc = 32'hFFFF_FFFC;
        hit("wrap", $urandom);
        check("wrap_addr0", 64'(imem.imemaddr), 64'h0);

        // Halt wins over JR and is sticky
        hit("pre_halt", $urandom);
        halt = 1'b1;
        PCSrc = PC_JR;
        jr_addr = 32'h300;
        imem.ihit = 1'b1;
        step();
        idle_inputs();
        check("halt_halted", 64'(halted), 64'd1);
        check("halt_ren", 64'(imem.imemREN), 64'd0);
        check("halt_addr", 64'(imem.imemaddr), 64'(exp_pc));
        check("halt_valid", 64'(valid_IF_ID), 64'd0);
        check("halt_instr", 64'(instr_IF_ID), 64'h0);
        check("halt_state", 64'(state), 64'(HALTED));
        for (int i = 0; i < 3; i++) begin
            imem.ihit = 1'b1;
            imem.imemload = $urandom;
            PCSrc = PC_BRANCH;
            branch_addr = 32'h80;
            stall = ($urandom_range(0, 1) == 1);
            step();
            check("halted_sticky", 64'(halted), 64'd1);
            check("halted_ren", 64'(imem.imemREN), 64'd0);
            check("halted_addr", 64'(imem.imemaddr), 64'(exp_pc));
            check("halted_valid", 64'(valid_IF_ID), 64'd0);
        end
        idle_inputs();

        // Asynchronous reset leaves HALTED immediately
        #1 nRST = 1'b0;
        #1;
        check("arst_halted", 64'(halted), 64'd0);
        check("arst_ren", 64'(imem.imemREN), 64'd1);
        check("arst_addr", 64'(imem.imemaddr), 64'h0);
        #1 nRST = 1'b1;
        exp_pc = 32'h0;
        hit("after_rst_a", $urandom);
        hit("after_rst_b", $urandom);

        // Mid-cycle reset discards the in-flight fetch
        imem.ihit = 1'b1;
        imem.imemload = $urandom;
        #1 nRST = 1'b0;
        #1;
        check("mid_rst_addr", 64'(imem.imemaddr), 64'h0);
        check("mid_rst_valid", 64'(valid_IF_ID), 64'd0);
        check("mid_rst_instr", 64'(instr_IF_ID), 64'h0);
        check("mid_rst_npc", 64'(npc_IF_ID), 64'h0);
        imem.ihit = 1'b0;
        #1 nRST = 1'b1;
        exp_pc = 32'h0;
        hit("final", $urandom);

        check("sb_empty", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage and IF/ID pipeline latch for the pipelined MIPS datapath. Holds the PC, drives the instruction-memory request, and registers fetched words into IF/ID. It consumes the control unit's `PCSrc` and `halt` decisions and produces the `opcode_IF_ID`, `func_IF_ID` and `imm16` fields that the control unit decodes.

## Interface

**Parameters**
- `PC_INIT`, default `32'h0000_0000`: PC value after reset.

**Ports**
- `CLK`, input, 1: clock; all state updates on the rising edge.
- `nRST`, input, 1: asynchronous reset, active-low.
- `ihit`, input, 1: instruction memory returned `imemload` for `imemaddr` this cycle.
- `imemload`, input, 32: instruction word.
- `PCSrc`, input, `pc_mux_input_selection`: next-PC select from the control unit.
- `halt`, input, 1: halt decoded in ID.
- `stall`, input, 1: hazard unit freezes PC and IF/ID.
- `flush`, input, 1: squash IF/ID without redirecting.
- `branch_addr`, input, 32: taken-branch target.
- `jr_addr`, input, 32: register target for JR.
- `imemREN`, output, 1: instruction read enable.
- `imemaddr`, output, 32: current PC.
- `instr_IF_ID`, output, 32: latched instruction.
- `npc_IF_ID`, output, 32: latched PC+4.
- `valid_IF_ID`, output, 1: latch holds a live instruction.
- `opcode_IF_ID`, output, 6: `instr_IF_ID[31:26]`.
- `func_IF_ID`, output, 6: `instr_IF_ID[5:0]`.
- `imm16`, output, 16: `instr_IF_ID[15:0]`.
- `halted`, output, 1: fetch permanently stopped.

## Operation

- **States** (`fetch_state_t`): `FETCH` and `HALTED`. Reset enters `FETCH`. `HALTED` is left only by reset.
- **Redirect:** occurs when `PCSrc != PC_NPC` in `FETCH`. Targets:
  - `PC_BRANCH` -> `branch_addr`.
  - `PC_JR` -> `jr_addr`.
  - `PC_JUMP` -> `{npc_IF_ID[31:28], instr_IF_ID[25:0], 2'b00}`, computed internally.
- **Priority each cycle in `FETCH`** (highest first):
  1. `halt` -> state `HALTED`; IF/ID cleared; PC frozen.
  2. Redirect -> PC <= target; IF/ID cleared. Any concurrent `ihit` word is discarded.
  3. `flush` -> IF/ID cleared. PC advances to PC+4 only if `ihit`, otherwise holds.
  4. `stall` -> PC and IF/ID hold, even if `ihit`; the word is re-fetched later.
  5. `ihit` -> IF/ID <= {`imemload`, PC+4, valid=1}; PC <= PC+4.
  6. Otherwise -> PC holds; `valid_IF_ID` <= 0 (bubble); instr/npc hold.
- **"Cleared"** means `instr_IF_ID` = 0 (a NOP), `npc_IF_ID` = 0, `valid_IF_ID` = 0.
- **`HALTED`:** `imemREN` = 0, `halted` = 1, all other inputs ignored.
- **Arithmetic:** PC+4 is 32-bit modulo, so `32'hFFFF_FFFC` wraps to 0. Low two PC bits are forced to 0 on every load.

## Timing

- **Reset values:**
  - PC = `PC_INIT`; `imemaddr` = `PC_INIT`.
  - `imemREN` = 1 (asserted combinationally in `FETCH`).
  - `instr_IF_ID` = 0, `npc_IF_ID` = 0, `valid_IF_ID` = 0.
  - `opcode_IF_ID` = 0, `func_IF_ID` = 0, `imm16` = 0.
  - `halted` = 0.
- `imemaddr` is combinational from the PC register. `imemREN` and `halted` are decoded from state.
- IF/ID outputs are registered. An instruction hit in cycle N is visible at IF/ID in cycle N+1.
- Latency: one cycle `ihit`-to-IF/ID; one cycle redirect-to-new-`imemaddr`. The redirected fetch issues in the cycle after the redirect is sampled.
- `ihit` may remain low for any number of cycles. The request holds address-stable the whole time unless a redirect or halt intervenes.
- Asserting `nRST` mid-fetch discards the in-flight request immediately (asynchronous).

## Configuration

Macro: `FETCH_PERF_EN`.
- **Defined:** adds outputs `fetch_count` (32) and `stall_count` (32), both reset to 0.
  - `fetch_count` increments on each accepted word (priority case 5).
  - `stall_count` increments on each `FETCH` cycle with `stall` high or `ihit` low.
  - Both counters freeze in `HALTED` and wrap at 2^32.
- **Undefined:** these ports and registers are absent; behaviour is otherwise identical.

## Structure

- `data_path_muxs_pkg` owns `pc_mux_input_selection`, with members `PC_NPC`, `PC_BRANCH`, `PC_JUMP`, `PC_JR`.
- `data_path_muxs_pkg` also owns the new `fetch_state_t` (`FETCH`, `HALTED`) and the `PC_INIT` default constant.
- `cpu_types_pkg` supplies `word_t`.
- One sub-module, `if_id_latch`: the IF/ID register with `load`, `clear`, `hold` controls and field extraction. `fetch_stage` holds the PC, the state machine and the next-PC mux.

## Test plan

- **Reset and sequential fetch:** reset, then `ihit`=1 for 3 cycles with words A, B, C -> `imemaddr` reads 0, 4, 8, 12. `instr_IF_ID` reads A, B, C one cycle after each hit. `valid_IF_ID`=1.
- **Stall with hit:** PC=8 with `stall`=1 and `ihit`=1 for 2 cycles -> `imemaddr` stays 8 and IF/ID holds. After release, the word at 8 is latched.
- **Branch over a pending hit:** `PCSrc`=`PC_BRANCH`, `branch_addr`=`32'h40`, `ihit`=1 in the same cycle -> next `imemaddr`=`32'h40`, `valid_IF_ID`=0, and the hit word is never latched.
- **Jump:** `instr_IF_ID`=`32'h0800_0010`, `npc_IF_ID`=`32'h1000_0004`, `PCSrc`=`PC_JUMP` -> next `imemaddr`=`32'h1000_0040`.
- **Halt is sticky:** `halt`=1 together with `PCSrc`=`PC_JR` -> `halted`=1 and `imemREN`=0 forever. PC stays frozen and later `ihit` pulses are ignored until `nRST`.
- **Wrap and asynchronous reset:** PC=`32'hFFFF_FFFC` with `ihit` -> `imemaddr`=0. Dropping `nRST` mid-cycle immediately restores `PC_INIT`, with `valid_IF_ID`=0.
